// File: rtl/display_resultado.sv
// display_resultado: shows the signed 32-bit ALU result on a multiplexed
// NUM_DIG-digit 7-segment display. A sequential double-dabble engine converts
// the value to BCD. The finished result is written into a display buffer in a
// single cycle, so the scan logic never shows a half-converted number.
module display_resultado #(
  parameter int NUM_DIG     = 4,
  parameter int DIV_SCAN    = 50000,
  parameter int ATIVO_BAIXO = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        valor,
  output logic [6:0]         segmentos,
  output logic [NUM_DIG-1:0] anodo,
  output logic               ocupado,
  output logic               estouro
);

  localparam int BW = 4 * NUM_DIG;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIG - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_SCAN - 1);

  localparam logic [6:0] SEG_MENOS   = 7'b1000000;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;
  localparam logic [6:0] SEG_ZERO    = 7'b0111111;

  // 10^n - 1, the largest magnitude that fits in n decimal digits
  function automatic logic [31:0] lim10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  // A negative value spends one digit on the sign
  localparam logic [31:0] LIM_POS = lim10(NUM_DIG);
  localparam logic [31:0] LIM_NEG = lim10(NUM_DIG - 1);

  localparam logic [NUM_DIG-1:0][6:0] DBUF_RST =
    {{((NUM_DIG - 1) * 7){1'b0}}, SEG_ZERO};

  typedef enum logic [1:0] {OCIOSO, CONVERTE, GRAVA} estado_t;

  // Unsigned magnitude; -2^31 maps to 0x80000000
  function automatic logic [31:0] magnitude(input logic signed [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Double-dabble correction: +3 on every nibble that is 5 or more
  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIG; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Decimal digit to active-high gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return SEG_APAGADO;
    endcase
  endfunction

  // Board polarity of the segment drive
  function automatic logic [6:0] pol(input logic [6:0] s);
    return (ATIVO_BAIXO != 0) ? ~s : s;
  endfunction

  estado_t                   state_q, state_d;
  logic signed [31:0]        valor_q, valor_d;
  logic [31:0]               mag_q, mag_d;
  logic [BW-1:0]             bcd_q, bcd_d;
  logic [5:0]                shcnt_q, shcnt_d;
  logic                      ocupado_q, ocupado_d;
  logic                      estouro_q, estouro_d;
  logic [NUM_DIG-1:0][6:0]   dbuf_q, dbuf_d;
  logic [CW-1:0]             scan_q, scan_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIG-1:0]        anodo_q, anodo_d;

  logic [BW-1:0]             bcd_adj;
  logic [31:0]               abs_cap;
  logic                      neg;
  logic                      ovf;
  int                        msd;

  // Conversion FSM next state: capture, shift/add-3, then publish to buffer
  always_comb begin
    state_d   = state_q;
    valor_d   = valor_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    shcnt_d   = shcnt_q;
    ocupado_d = ocupado_q;
    estouro_d = estouro_q;
    dbuf_d    = dbuf_q;

    bcd_adj = dd_adjust(bcd_q);
    abs_cap = magnitude(valor_q);
    neg     = valor_q[31];
    ovf     = neg ? (abs_cap > LIM_NEG) : (abs_cap > LIM_POS);
    msd     = 0;
    for (int i = 0; i < NUM_DIG; i++)
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;

    case (state_q)
      OCIOSO: begin
        if (valor != valor_q) begin
          valor_d   = valor;
          mag_d     = magnitude(valor);
          bcd_d     = '0;
          shcnt_d   = 6'd0;
          ocupado_d = 1'b1;
          state_d   = CONVERTE;
        end
      end
      CONVERTE: begin
        if (shcnt_q == 6'd32) begin
          state_d = GRAVA;
        end else begin
          {bcd_d, mag_d} = {bcd_adj[BW-2:0], mag_q, 1'b0};
          shcnt_d        = shcnt_q + 6'd1;
        end
      end
      GRAVA: begin
        for (int i = 0; i < NUM_DIG; i++) begin
          if (ovf)                        dbuf_d[i] = SEG_MENOS;
          else if (i <= msd)              dbuf_d[i] = seg7(bcd_q[4*i +: 4]);
          else if (neg && (i == msd + 1)) dbuf_d[i] = SEG_MENOS;
          else                            dbuf_d[i] = SEG_APAGADO;
        end
        estouro_d = ovf;
        ocupado_d = 1'b0;
        state_d   = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  // Scan next state; digit select and segments come from the same index and
  // the post-edge buffer, so both change together on one edge
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == CNT_MAX) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      scan_d = scan_q + CW'(1);
    end
    seg_d   = pol(dbuf_d[idx_d]);
    anodo_d = ~({{(NUM_DIG - 1){1'b0}}, 1'b1} << idx_d);
  end

  // All state, with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= OCIOSO;
      valor_q   <= '0;
      mag_q     <= '0;
      bcd_q     <= '0;
      shcnt_q   <= '0;
      ocupado_q <= 1'b0;
      estouro_q <= 1'b0;
      dbuf_q    <= DBUF_RST;
      scan_q    <= '0;
      idx_q     <= '0;
      seg_q     <= pol(SEG_ZERO);
      anodo_q   <= ~{{(NUM_DIG - 1){1'b0}}, 1'b1};
    end else begin
      state_q   <= state_d;
      valor_q   <= valor_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      shcnt_q   <= shcnt_d;
      ocupado_q <= ocupado_d;
      estouro_q <= estouro_d;
      dbuf_q    <= dbuf_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      anodo_q   <= anodo_d;
    end
  end

  assign segmentos = seg_q;
  assign anodo     = anodo_q;
  assign ocupado   = ocupado_q;
  assign estouro   = estouro_q;

endmodule

// File: tb/tb_display_resultado.sv
// Testbench for display_resultado with NUM_DIG=4, DIV_SCAN=4, ATIVO_BAIXO=1.
// Expected displays come from a decimal-arithmetic model of the value.
module tb_display_resultado;

  localparam int NUM_DIG  = 4;
  localparam int DIV_SCAN = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] valor = 32'd0;
  logic [6:0]  segmentos;
  logic [3:0]  anodo;
  logic        ocupado;
  logic        estouro;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur = 32'd0;

  logic       rec_ocu [100];
  logic [3:0] rec_an  [100];
  logic [6:0] rec_sg  [100];

  always #5 clock = ~clock;

  display_resultado #(.NUM_DIG(NUM_DIG), .DIV_SCAN(DIV_SCAN), .ATIVO_BAIXO(1)) dut (
    .clock(clock), .reset_n(reset_n), .valor(valor),
    .segmentos(segmentos), .anodo(anodo), .ocupado(ocupado), .estouro(estouro)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference: active-low pattern each digit must show, and overflow flag
  task automatic model(input logic [31:0] v, output logic [3:0][6:0] disp, output logic ovf);
    longint s, m, p, q;
    int nd;
    bit ng;
    s  = longint'($signed(v));
    ng = (s < 0);
    m  = ng ? -s : s;
    ovf = ng ? (m > 999) : (m > 9999);
    nd = 1;
    p  = 10;
    while (m >= p && nd < 12) begin nd++; p = p * 10; end
    for (int i = 0; i < NUM_DIG; i++) begin
      q = 1;
      for (int k = 0; k < i; k++) q = q * 10;
      if (ovf)                  disp[i] = ~7'b1000000;
      else if (i < nd)          disp[i] = ~seg_of(int'((m / q) % 10));
      else if (ng && i == nd)   disp[i] = ~7'b1000000;
      else                      disp[i] = ~7'b0000000;
    end
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watch two full scan rounds and collect what each digit shows
  task automatic read_display(output logic [3:0][6:0] got, output bit ok);
    logic [3:0] seen;
    int ix;
    got = '0; seen = '0; ok = 1'b1;
    for (int k = 0; k < 2 * NUM_DIG * DIV_SCAN; k++) begin
      @(negedge clock);
      ix = an_idx(anodo);
      if (ix < 0) ok = 1'b0;
      else begin got[ix] = segmentos; seen[ix] = 1'b1; end
    end
    if (seen != 4'hF) ok = 1'b0;
  endtask

  // Apply a value and measure how long ocupado stays high
  task automatic run_conv(input logic [31:0] v, output int busy, output bit tmo);
    int w;
    valor = v; cur = v; busy = 0; tmo = 1'b0; w = 0;
    @(negedge clock);
    while (!ocupado && w < 5) begin @(negedge clock); w++; end
    if (!ocupado) tmo = 1'b1;
    else begin
      while (ocupado && busy < 200) begin busy++; @(negedge clock); end
      if (busy >= 200) tmo = 1'b1;
    end
  endtask

  task automatic check_value(input logic [31:0] v);
    int busy; bit tmo, ok;
    logic [3:0][6:0] exp_d, got;
    logic exp_o;
    run_conv(v, busy, tmo);
    checks++;
    if (tmo || busy != 34) begin
      errors++;
      $display("FAIL busy_len valor=%0d: got %0d cycles (timeout=%0b), expected 34", $signed(v), busy, tmo);
    end
    model(v, exp_d, exp_o);
    checks++;
    if (estouro !== exp_o) begin
      errors++;
      $display("FAIL estouro valor=%0d: got %b, expected %b", $signed(v), estouro, exp_o);
    end
    read_display(got, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL anodo_scan valor=%0d: invalid or missing digit select", $signed(v));
    end
    for (int i = 0; i < NUM_DIG; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL digit%0d valor=%0d: got %b, expected %b", i, $signed(v), got[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    logic [6:0] es;
    reset_n = 1'b0; valor = 32'd0; cur = 32'd0;
    repeat (3) @(negedge clock);
    checks++;
    if (ocupado !== 1'b0 || estouro !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ocupado=%b estouro=%b, expected 0 0", ocupado, estouro);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      ea = ~(4'b0001 << ((k / DIV_SCAN) % NUM_DIG));
      es = (ea == 4'b1110) ? 7'b1000000 : 7'b1111111;
      checks++;
      if (anodo !== ea || segmentos !== es || ocupado !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan k=%0d: anodo=%b seg=%b ocupado=%b, expected %b %b 0",
                 k, anodo, segmentos, ocupado, ea, es);
      end
    end
  endtask

  task automatic test_values();
    logic [31:0] tv [12];
    tv = '{32'd1234, -32'sd5, 32'd10000, -32'sd1000, -32'sd999, 32'd9999,
           -32'sd1, 32'd0, 32'd1000, 32'h7FFFFFFF, 32'd10, -32'sd90};
    foreach (tv[i]) check_value(tv[i]);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int n = 0; n < 14; n++) begin
      case (n % 4)
        0: v = $urandom_range(0, 9999);
        1: v = -$urandom_range(0, 999);
        2: v = $urandom();
        default: v = $urandom_range(0, 99);
      endcase
      if (v == cur) v = v + 32'd1;
      check_value(v);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][6:0] got, exp_d;
    logic exp_o;
    int r1, gap, r2, i, ix;
    bit ok;
    valor = 32'd7; cur = 32'd7;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      rec_ocu[k] = ocupado; rec_an[k] = anodo; rec_sg[k] = segmentos;
      if (k == 9) begin valor = 32'd42; cur = 32'd42; end
    end
    i = 0; r1 = 0; gap = 0; r2 = 0;
    while (i < 100 && rec_ocu[i] === 1'b1) begin r1++; i++; end
    while (i < 100 && rec_ocu[i] === 1'b0) begin gap++; i++; end
    while (i < 100 && rec_ocu[i] === 1'b1) begin r2++; i++; end
    checks++;
    if (r1 != 34 || gap != 1 || r2 != 34) begin
      errors++;
      $display("FAIL b2b_ocupado: runs %0d/%0d/%0d, expected 34/1/34", r1, gap, r2);
    end
    for (int w = 0; w < 2; w++) begin
      got = '0; ok = 1'b1;
      for (int k = 0; k < 16; k++) begin
        ix = an_idx(rec_an[(w ? 70 : 35) + k]);
        if (ix < 0) ok = 1'b0; else got[ix] = rec_sg[(w ? 70 : 35) + k];
      end
      model(w ? 32'd42 : 32'd7, exp_d, exp_o);
      checks++;
      if (!ok || got !== exp_d) begin
        errors++;
        $display("FAIL b2b_display%0d: got %h, expected %h", w, got, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid();
    valor = 32'h80000000; cur = 32'h80000000;
    repeat (10) @(negedge clock);
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: ocupado=%b, expected 1", ocupado);
    end
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (ocupado !== 1'b0 || estouro !== 1'b0 || anodo !== 4'b1110 || segmentos !== 7'b1000000) begin
      errors++;
      $display("FAIL mid_reset: ocupado=%b estouro=%b anodo=%b seg=%b, expected 0 0 1110 1000000",
               ocupado, estouro, anodo, segmentos);
    end
    reset_n = 1'b1;
    check_value(32'h80000000);
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_resultado.md
Name: display_resultado

Overview:
- Downstream consumer of the ALU result in the single-cycle MIPS top.
- Takes the 32-bit signed `alu_resultado` and converts it to decimal with a sequential double-dabble engine.
- Drives a multiplexed NUM_DIG-digit 7-segment display on the FPGA board, with leading-zero blanking, a minus sign and an overflow indication.
- Double-buffered, so the displayed value never tears mid-conversion.

Parameters:
- NUM_DIG, 4: number of display digits (2..8).
- DIV_SCAN, 50000: clock cycles each digit stays lit (≥2).
- ATIVO_BAIXO, 1: 1 = segment outputs active-low, 0 = active-high.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- valor  input  32  two's-complement value to show (ALU result).
- segmentos  output  7  segment drive, bit6=g … bit0=a, polarity per ATIVO_BAIXO.
- anodo  output  NUM_DIG  digit select, one-hot active-low; bit0 = rightmost (least significant) digit.
- ocupado  output  1  high while a conversion is in progress.
- estouro  output  1  high while the displayed value does not fit.

Behaviour:
- One clock; reset_n is synchronous and active-low. All outputs are registered.
- Reset values:
  - FSM = OCIOSO; captured value = 0; ocupado = 0; estouro = 0.
  - Display buffer shows "0": digit0 = '0', all other digits blank.
  - Scan counter = 0; digit index = 0, so anodo = all ones except bit0 = 0.
- Reset asserted mid-conversion aborts it and restores the reset state on the next edge.
- FSM OCIOSO:
  - If valor ≠ captured value: capture valor, load magnitude = |valor| (−2^31 gives 0x80000000 unsigned), clear the BCD register, set shift count = 0, set ocupado = 1, go to CONVERTE.
  - Otherwise stay.
- FSM CONVERTE:
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {BCD, magnitude} left by 1.
  - The BCD register is 4·NUM_DIG bits; higher bits are discarded.
  - After 32 shifts go to GRAVA.
  - valor is ignored in this state.
- FSM GRAVA (1 cycle):
  - Compute blanking, sign and overflow, and write the display buffer and estouro.
  - ocupado = 0; go to OCIOSO.
- Latency: valor change seen at edge N → ocupado = 1 after N; display buffer and estouro updated at edge N+34; ocupado = 0 after N+34.
- A valor that changes during a conversion is picked up by the OCIOSO compare after GRAVA. Last value wins; intermediate values may never be shown.
- Overflow (estouro = 1):
  - Non-negative valor: magnitude > 10^NUM_DIG − 1.
  - Negative valor: magnitude > 10^(NUM_DIG−1) − 1 (the sign needs its own digit).
  - Decided by magnitude comparison, not from the truncated BCD.
  - On overflow every digit shows '-' (only segment g lit).
- Blanking:
  - Digits above the most significant nonzero digit are blank; digit0 always shows its digit, so 0 shows "0".
  - Negative values: '-' goes in the digit immediately left of the most significant digit.
- Encoding (active-high gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - '-'=1000000, blank=0000000.
  - Inverted on output when ATIVO_BAIXO=1.
- Scan:
  - The counter runs 0..DIV_SCAN−1. On wrap, the digit index increments, wrapping from NUM_DIG−1 to 0.
  - segmentos and anodo update together on the same edge, so no ghosting.
  - Scanning is independent of the FSM and reads only the display buffer.

Test Plan (NUM_DIG=4, DIV_SCAN=4, ATIVO_BAIXO=1):
1. Reset with valor=0 → anodo=1110 with segmentos=1000000 ('0'); other anodo phases show segmentos=1111111; ocupado=0, estouro=0; no conversion starts.
2. valor=1234 → ocupado high exactly 34 cycles; then phases 1110/1101/1011/0111 show 0011001('4'), 0110000('3'), 0100100('2'), 1111001('1'); estouro=0.
3. valor=−5 (0xFFFFFFFB) → digit0=0010010('5'), digit1=0111111('-'), digits 2–3 blank; estouro=0.
4. valor=10000, then valor=−1000 → each gives estouro=1 and all four digits 0111111; then valor=−999 → estouro=0, display "-999".
5. valor=7, then valor=42 applied 10 cycles into the conversion → "7" appears at +34 cycles; a second conversion starts the following cycle; "42" appears 35 cycles after that; ocupado low for exactly 1 cycle between the two conversions.
6. reset_n=0 for one cycle during conversion of valor=−2147483648 → next cycle shows "0", ocupado=0. After release with valor unchanged: conversion runs, estouro=1, display "----".
